// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states,
// default RAM address width and access legality helpers.
`default_nettype none

package mem_access_ctrl_pkg;

  localparam int MEM_AW_DEF = 12;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: f3_misaligned = off[0];
      F3_W:        f3_misaligned = (off != 2'b00);
      default:     f3_misaligned = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_lane_align.sv
// Byte-lane steering: extends load data from a RAM word and merges
// sub-word store data into a previously read RAM word.
`default_nettype none

module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load = {24'h000000, w_byte};
      F3_HU:   o_load = {16'h0000, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_store = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_off)
          2'd0: o_store[7:0]   = i_wdata[7:0];
          2'd1: o_store[15:8]  = i_wdata[7:0];
          2'd2: o_store[23:16] = i_wdata[7:0];
          2'd3: o_store[31:24] = i_wdata[7:0];
          default: o_store = i_word;
        endcase
      end
      F3_H: begin
        if (i_off[1]) o_store[31:16] = i_wdata[15:0];
        else          o_store[15:0]  = i_wdata[15:0];
      end
      F3_W:    o_store = i_wdata;
      default: o_store = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port word RAM,
// with read-modify-write for sub-word stores and access error detection.
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic        r_err;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_store;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_err    = !f3_legal(req_we, req_funct3)
                 || f3_misaligned(req_funct3, req_addr[1:0])
                 || ((req_addr >> MEM_AW) != 32'd0);

  mem_lane_align u_align (
    .i_word   (r_word),
    .i_wdata  (r_wdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_err;
      end
      if (r_state == ST_RDW) r_word <= mem_rdata;
    end
  end

  // Full-word stores skip the read; sub-word stores go through RD/RDW first.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    busy         = 1'b1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_wdata    = 32'd0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = 32'd0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept) begin
          if (w_err)                                w_next = ST_ERR;
          else if (req_we && req_funct3 == F3_W)    w_next = ST_WR;
          else                                      w_next = ST_RD;
        end
      end
      ST_RD: begin
        mem_read_en = 1'b1;
        w_next      = ST_RDW;
      end
      ST_RDW: w_next = r_we ? ST_WR : ST_RESP;
      ST_WR: begin
        mem_write_en = 1'b1;
        mem_wdata    = w_store;
        w_next       = ST_RESP;
      end
      ST_ERR: w_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_we && !r_err) resp_rdata = w_load;
        w_next     = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign mem_addr = {r_addr[31:2], 2'b00};

endmodule

`default_nettype wire
